reset_sequencer: RTL and testbench

Parametrised successor to the single-output power-up reset generator. Produces CHANNELS staged, active-high reset outputs released one at a time in index order. It accepts a synchronised, debounced asynchronous button request (key) and a per-channel soft-reset request. Sits at the top of the synth design, driving resets to MIDI input, voice engine, DAC interface and other domains in dependency order.

---
 rtl/reset_sequencer_if.sv | 30 +++
 rtl/reset_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if
// Groups the request inputs and reset/status outputs of reset_sequencer.
//   key       : asynchronous button request, active-high
//   soft_req  : single-cycle soft reset request
//   soft_mask : channels re-reset by soft_req
//   rst_out   : per-channel active-high reset
//   ready     : every channel released
//   busy      : release sequence in progress
// The master modport is the requester/observer side; the slave modport is
// the sequencer itself.
interface reset_sequencer_if #(
  parameter int CHANNELS = 4
);
  logic                key;
  logic                soft_req;
  logic [CHANNELS-1:0] soft_mask;
  logic [CHANNELS-1:0] rst_out;
  logic                ready;
  logic                busy;

  modport master (
    output key, soft_req, soft_mask,
    input  rst_out, ready, busy
  );

  modport slave (
    input  key, soft_req, soft_mask,
    output rst_out, ready, busy
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Generates CHANNELS staged active-high resets, released one at a time in
// index order after a hold period. Hard requests come from rst or from a
// synchronised, debounced key; soft requests re-reset a masked subset of
// channels while the block is in RUN.
// Ports:
//   clk : system clock
//   rst : synchronous active-high reset (acts as a power-up hard request)
//   bus : reset_sequencer_if.slave carrying key, soft_req, soft_mask,
//         rst_out, ready, busy (all outputs registered)
module reset_sequencer #(
  parameter int CHANNELS    = 4,
  parameter int DELAY_W     = 8,
  parameter int HOLD_DELAY  = 15,
  parameter int STAGE_DELAY = 3,
  parameter int DEBOUNCE    = 4
) (
  input  logic               clk,
  input  logic               rst,
  reset_sequencer_if.slave   bus
);

  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DB_W  = (DEBOUNCE > 0) ? $clog2(DEBOUNCE + 1) : 1;

  localparam logic [DELAY_W-1:0]  HOLD_CNT  = DELAY_W'(HOLD_DELAY);
  localparam logic [DELAY_W-1:0]  STAGE_CNT = DELAY_W'(STAGE_DELAY);
  localparam logic [DB_W-1:0]     DB_MAX    = DB_W'(DEBOUNCE);
  localparam logic [CHANNELS-1:0] ALL_ONES  = {CHANNELS{1'b1}};
  localparam logic [CHANNELS-1:0] ALL_ZEROS = {CHANNELS{1'b0}};

  typedef enum logic {
    ST_SEQ = 1'b0,
    ST_RUN = 1'b1
  } state_t;

  logic                key_meta_r;
  logic                key_s_r;
  logic [DB_W-1:0]     db_cnt_r;
  logic                key_req_s;

  state_t              state_r;
  state_t              state_n_s;
  logic [DELAY_W-1:0]  cnt_r;
  logic [DELAY_W-1:0]  cnt_n_s;
  logic [CHANNELS-1:0] pending_r;
  logic [CHANNELS-1:0] pending_n_s;
  logic [CHANNELS-1:0] rst_out_r;
  logic [CHANNELS-1:0] rst_out_n_s;
  logic                ready_r;
  logic                ready_n_s;
  logic                busy_r;
  logic                busy_n_s;

  logic [IDX_W-1:0]    low_idx_s;
  logic [CHANNELS-1:0] low_bit_s;
  logic                last_s;

  // Key synchroniser and debounce counter; these keep running during a
  // key-driven hard request so the request can end on its own.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_meta_r <= 1'b0;
      key_s_r    <= 1'b0;
      db_cnt_r   <= {DB_W{1'b0}};
    end else begin
      key_meta_r <= bus.key;
      key_s_r    <= key_meta_r;
      if (key_s_r) begin
        if (db_cnt_r != DB_MAX) begin
          db_cnt_r <= db_cnt_r + DB_W'(1);
        end else begin
          db_cnt_r <= db_cnt_r;
        end
      end else begin
        db_cnt_r <= {DB_W{1'b0}};
      end
    end
  end

  // With DEBOUNCE=0 the counter is pinned at zero, so key_s alone requests.
  assign key_req_s = key_s_r && (db_cnt_r == DB_MAX);

  // Lowest set pending index; scanning downward lets the lowest hit win.
  always_comb begin
    low_idx_s = {IDX_W{1'b0}};
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pending_r[i]) begin
        low_idx_s = IDX_W'(i);
      end else begin
        low_idx_s = low_idx_s;
      end
    end
  end

  assign low_bit_s = CHANNELS'(1'b1) << low_idx_s;
  assign last_s    = ((pending_r & ~low_bit_s) == ALL_ZEROS);

  // Next-state and next-output logic; a key request dominates soft_req.
  always_comb begin
    state_n_s   = state_r;
    cnt_n_s     = cnt_r;
    pending_n_s = pending_r;
    rst_out_n_s = rst_out_r;
    ready_n_s   = ready_r;
    busy_n_s    = busy_r;

    if (key_req_s) begin
      state_n_s   = ST_SEQ;
      cnt_n_s     = HOLD_CNT;
      pending_n_s = ALL_ONES;
      rst_out_n_s = ALL_ONES;
      ready_n_s   = 1'b0;
      busy_n_s    = 1'b1;
    end else begin
      case (state_r)
        ST_SEQ: begin
          if (cnt_r != {DELAY_W{1'b0}}) begin
            cnt_n_s = cnt_r - DELAY_W'(1);
          end else begin
            rst_out_n_s = rst_out_r & ~low_bit_s;
            pending_n_s = pending_r & ~low_bit_s;
            if (last_s) begin
              state_n_s = ST_RUN;
              ready_n_s = 1'b1;
              busy_n_s  = 1'b0;
            end else begin
              cnt_n_s = STAGE_CNT;
            end
          end
        end
        ST_RUN: begin
          if (bus.soft_req && (bus.soft_mask != ALL_ZEROS)) begin
            state_n_s   = ST_SEQ;
            cnt_n_s     = HOLD_CNT;
            pending_n_s = bus.soft_mask;
            rst_out_n_s = rst_out_r | bus.soft_mask;
            ready_n_s   = 1'b0;
            busy_n_s    = 1'b1;
          end else begin
            state_n_s = ST_RUN;
          end
        end
        default: begin
          // Unreachable encoding: recover through a full sequence.
          state_n_s   = ST_SEQ;
          cnt_n_s     = HOLD_CNT;
          pending_n_s = ALL_ONES;
          rst_out_n_s = ALL_ONES;
          ready_n_s   = 1'b0;
          busy_n_s    = 1'b1;
        end
      endcase
    end
  end

  // Sequencer state and output registers; rst applies the power-up values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_SEQ;
      cnt_r     <= HOLD_CNT;
      pending_r <= ALL_ONES;
      rst_out_r <= ALL_ONES;
      ready_r   <= 1'b0;
      busy_r    <= 1'b1;
    end else begin
      state_r   <= state_n_s;
      cnt_r     <= cnt_n_s;
      pending_r <= pending_n_s;
      rst_out_r <= rst_out_n_s;
      ready_r   <= ready_n_s;
      busy_r    <= busy_n_s;
    end
  end

  assign bus.rst_out = rst_out_r;
  assign bus.ready   = ready_r;
  assign bus.busy    = busy_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer
// Directed self-checking bench for reset_sequencer: default-parameter
// instance plus a corner instance (CHANNELS=1, zero delays, no debounce).
// Edge numbers in the tasks count clock edges after the reference edge
// (last request-high edge, or the edge that samples a new input).
module tb_reset_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic rst_c;
  int   tests_run = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  reset_sequencer_if #(.CHANNELS(4)) bus ();
  reset_sequencer_if #(.CHANNELS(1)) bus_c ();

  reset_sequencer #(
    .CHANNELS(4), .DELAY_W(8), .HOLD_DELAY(15), .STAGE_DELAY(3), .DEBOUNCE(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  reset_sequencer #(
    .CHANNELS(1), .DELAY_W(8), .HOLD_DELAY(0), .STAGE_DELAY(0), .DEBOUNCE(0)
  ) dut_c (
    .clk(clk), .rst(rst_c), .bus(bus_c)
  );

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    logic [3:0] exp;
    rst = 1'b1;
    tick(1);
    tests_run++;
    if (bus.rst_out !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_rst_out: got %h expected %h", bus.rst_out, 4'hF);
    end
    tests_run++;
    if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_status: got ready=%b busy=%b expected ready=0 busy=1", bus.ready, bus.busy);
    end
    tick(2);
    rst = 1'b0;
    for (int k = 1; k <= 28; k++) begin
      tick(1);
      exp = (k < 16) ? 4'hF : (k < 20) ? 4'hE : (k < 24) ? 4'hC : (k < 28) ? 4'h8 : 4'h0;
      tests_run++;
      if (bus.rst_out !== exp || bus.ready !== (k == 28) || bus.busy !== (k < 28)) begin
        tests_failed++;
        $display("FAIL powerup_seq edge %0d: got rst_out=%h ready=%b busy=%b expected %h %b %b",
                 k, bus.rst_out, bus.ready, bus.busy, exp, (k == 28), (k < 28));
      end
    end
  endtask

  task automatic test_key();
    // Short glitch: three sampled-high cycles never reach the debounce limit.
    bus.key = 1'b1;
    tick(3);
    bus.key = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      tests_run++;
      if (bus.rst_out !== 4'h0 || bus.ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL key_glitch cycle %0d: got rst_out=%h ready=%b expected 0 1", k, bus.rst_out, bus.ready);
      end
    end
    // Held key: sampled high on edges 1..20, last key_req-high edge is 22.
    bus.key = 1'b1;
    for (int k = 1; k <= 50; k++) begin
      tick(1);
      if (k == 20) bus.key = 1'b0;
      if (k == 6) begin
        tests_run++;
        if (bus.rst_out !== 4'h0) begin
          tests_failed++;
          $display("FAIL key_early edge 6: got %h expected %h", bus.rst_out, 4'h0);
        end
      end
      if (k == 7) begin
        tests_run++;
        if (bus.rst_out !== 4'hF || bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL key_assert edge 7: got rst_out=%h ready=%b busy=%b expected F 0 1", bus.rst_out, bus.ready, bus.busy);
        end
      end
      if (k == 37 || k == 38 || k == 42 || k == 46 || k == 50) begin
        tests_run++;
        if (bus.rst_out !== ((k == 37) ? 4'hF : (k == 38) ? 4'hE : (k == 42) ? 4'hC : (k == 46) ? 4'h8 : 4'h0)) begin
          tests_failed++;
          $display("FAIL key_release edge %0d: got rst_out=%h", k, bus.rst_out);
        end
      end
    end
    tests_run++;
    if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL key_ready: got ready=%b busy=%b expected 1 0", bus.ready, bus.busy);
    end
  endtask

  task automatic test_soft();
    bus.soft_req = 1'b1;
    bus.soft_mask = 4'b1010;
    tick(1);
    bus.soft_req = 1'b0;
    bus.soft_mask = 4'b0000;
    tests_run++;
    if (bus.rst_out !== 4'hA || bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL soft_assert: got rst_out=%h ready=%b busy=%b expected A 0 1", bus.rst_out, bus.ready, bus.busy);
    end
    for (int k = 2; k <= 21; k++) begin
      tick(1);
      tests_run++;
      if ((bus.rst_out & 4'b0101) !== 4'b0000) begin
        tests_failed++;
        $display("FAIL soft_unmasked edge %0d: got %h expected bits 0,2 low", k, bus.rst_out);
      end
      if (k == 16 || k == 17 || k == 20 || k == 21) begin
        tests_run++;
        if (bus.rst_out !== ((k == 16) ? 4'hA : (k == 21) ? 4'h0 : 4'h8) || bus.ready !== (k == 21)) begin
          tests_failed++;
          $display("FAIL soft_seq edge %0d: got rst_out=%h ready=%b", k, bus.rst_out, bus.ready);
        end
      end
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL soft_busy: got %b expected 0", bus.busy);
    end
  endtask

  task automatic test_ignored_soft();
    bus.soft_req = 1'b1;
    bus.soft_mask = 4'b0000;
    tick(1);
    bus.soft_req = 1'b0;
    tests_run++;
    if (bus.rst_out !== 4'h0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL soft_zero_mask: got rst_out=%h ready=%b busy=%b expected 0 1 0", bus.rst_out, bus.ready, bus.busy);
    end
    bus.soft_req = 1'b1;
    bus.soft_mask = 4'b0001;
    tick(1);
    bus.soft_req = 1'b0;
    bus.soft_mask = 4'b0000;
    tests_run++;
    if (bus.rst_out !== 4'h1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL soft_single: got rst_out=%h busy=%b expected 1 1", bus.rst_out, bus.busy);
    end
    for (int k = 2; k <= 17; k++) begin
      if (k == 5) begin
        bus.soft_req = 1'b1;
        bus.soft_mask = 4'b1110;
      end
      tick(1);
      bus.soft_req = 1'b0;
      bus.soft_mask = 4'b0000;
      if (k == 5 || k == 16 || k == 17) begin
        tests_run++;
        if (bus.rst_out !== ((k == 17) ? 4'h0 : 4'h1) || bus.ready !== (k == 17)) begin
          tests_failed++;
          $display("FAIL soft_in_seq edge %0d: got rst_out=%h ready=%b", k, bus.rst_out, bus.ready);
        end
      end
    end
  endtask

  task automatic test_hard_over_soft();
    logic [3:0] exp;
    bus.soft_req = 1'b1;
    bus.soft_mask = 4'b1010;
    tick(1);
    bus.soft_req = 1'b0;
    bus.soft_mask = 4'b0000;
    tick(4);
    rst = 1'b1;
    bus.soft_req = 1'b1;
    bus.soft_mask = 4'b0101;
    tick(1);
    rst = 1'b0;
    bus.soft_req = 1'b0;
    bus.soft_mask = 4'b0000;
    tests_run++;
    if (bus.rst_out !== 4'hF || bus.ready !== 1'b0 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL hard_over_soft: got rst_out=%h ready=%b busy=%b expected F 0 1", bus.rst_out, bus.ready, bus.busy);
    end
    for (int k = 1; k <= 28; k++) begin
      tick(1);
      exp = (k < 16) ? 4'hF : (k < 20) ? 4'hE : (k < 24) ? 4'hC : (k < 28) ? 4'h8 : 4'h0;
      tests_run++;
      if (bus.rst_out !== exp || bus.ready !== (k == 28)) begin
        tests_failed++;
        $display("FAIL hard_restart edge %0d: got rst_out=%h ready=%b expected %h %b",
                 k, bus.rst_out, bus.ready, exp, (k == 28));
      end
    end
  endtask

  task automatic test_corner();
    rst_c = 1'b1;
    tick(1);
    tests_run++;
    if (bus_c.rst_out !== 1'b1 || bus_c.ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_reset: got rst_out=%b ready=%b expected 1 0", bus_c.rst_out, bus_c.ready);
    end
    rst_c = 1'b0;
    tick(1);
    tests_run++;
    if (bus_c.rst_out !== 1'b0 || bus_c.ready !== 1'b1 || bus_c.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_release: got rst_out=%b ready=%b busy=%b expected 0 1 0", bus_c.rst_out, bus_c.ready, bus_c.busy);
    end
    bus_c.key = 1'b1;
    tick(2);
    tests_run++;
    if (bus_c.rst_out !== 1'b0) begin
      tests_failed++;
      $display("FAIL corner_key_sync edge 2: got %b expected 0", bus_c.rst_out);
    end
    tick(1);
    bus_c.key = 1'b0;
    tests_run++;
    if (bus_c.rst_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL corner_key_assert edge 3: got %b expected 1", bus_c.rst_out);
    end
    tick(2);
    tests_run++;
    if (bus_c.rst_out !== 1'b1) begin
      tests_failed++;
      $display("FAIL corner_key_hold edge 5: got %b expected 1", bus_c.rst_out);
    end
    tick(1);
    tests_run++;
    if (bus_c.rst_out !== 1'b0 || bus_c.ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL corner_key_release edge 6: got rst_out=%b ready=%b expected 0 1", bus_c.rst_out, bus_c.ready);
    end
  endtask

  initial begin
    rst = 1'b1;
    rst_c = 1'b1;
    bus.key = 1'b0;
    bus.soft_req = 1'b0;
    bus.soft_mask = 4'b0000;
    bus_c.key = 1'b0;
    bus_c.soft_req = 1'b0;
    bus_c.soft_mask = 1'b0;
    #1;
    test_reset();
    test_key();
    test_soft();
    test_ignored_soft();
    test_hard_over_soft();
    test_corner();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
